// File: rtl/ddr4_rx_lane_aligner_pkg.sv
// Shared types for the DDR4 receive lane aligner.
// Provides the FSM state enum, default training word and counter sizing.
package ddr4_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } aligner_state_t;

  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'h1E;

  function automatic int wait_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ddr4_rx_lane_aligner_if.sv
// Lane bundle between the aligner and one input IOD.
// master: aligner (drives slip/move/load), slave: IOD side.
interface ddr4_rx_lane_aligner_if #(
  parameter int RX_WIDTH = 8
);

  logic [RX_WIDTH-1:0] RX_DATA_0;
  logic                DELAY_LINE_OUT_OF_RANGE_0;
  logic                RX_BIT_SLIP_0;
  logic                DELAY_LINE_MOVE_0;
  logic                DELAY_LINE_DIRECTION_0;
  logic                DELAY_LINE_LOAD_0;

  modport master (
    input  RX_DATA_0,
    input  DELAY_LINE_OUT_OF_RANGE_0,
    output RX_BIT_SLIP_0,
    output DELAY_LINE_MOVE_0,
    output DELAY_LINE_DIRECTION_0,
    output DELAY_LINE_LOAD_0
  );

  modport slave (
    output RX_DATA_0,
    output DELAY_LINE_OUT_OF_RANGE_0,
    input  RX_BIT_SLIP_0,
    input  DELAY_LINE_MOVE_0,
    input  DELAY_LINE_DIRECTION_0,
    input  DELAY_LINE_LOAD_0
  );

endinterface

// File: rtl/ddr4_rx_lane_aligner_pattern_checker.sv
// Registered compare of the lane word against the training pattern.
// Ports: clk, rst_n, en (sample), clr (drop run), rx_data; strobes match_ok, mismatch.
module ddr4_rx_pattern_checker
  import ddr4_phy_pkg::*;
#(
  parameter int                  RX_WIDTH    = 8,
  parameter logic [RX_WIDTH-1:0] PATTERN     = RX_WIDTH'(DEF_TRAIN_PATTERN),
  parameter int                  MATCH_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [RX_WIDTH-1:0] rx_data,
  output logic                match_ok,
  output logic                mismatch
);

  logic [3:0] run;

  // Strobes are one-cycle results of the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= '0;
      match_ok <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      match_ok <= 1'b0;
      mismatch <= 1'b0;
      if (clr) begin
        run <= '0;
      end else if (en) begin
        if (rx_data == PATTERN) begin
          run      <= run + 4'd1;
          match_ok <= (run == 4'(MATCH_COUNT - 1));
        end else begin
          run      <= '0;
          mismatch <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr4_rx_lane_aligner.sv
// DDR4 RX lane aligner: bitslip then delay-step until the training word locks.
// Ports: FAB_CLK, ARST_N, TRAIN_START, iod lane bundle, aligned data and status.
module ddr4_rx_lane_aligner
  import ddr4_phy_pkg::*;
#(
  parameter int                  RX_WIDTH      = 8,
  parameter logic [RX_WIDTH-1:0] TRAIN_PATTERN = RX_WIDTH'(DEF_TRAIN_PATTERN),
  parameter int                  MATCH_COUNT   = 4,
  parameter int                  SETTLE_CYCLES = 8,
  parameter int                  MAX_TAPS      = 127
) (
  input  logic                   FAB_CLK,
  input  logic                   ARST_N,
  input  logic                   TRAIN_START,
  ddr4_rx_lane_aligner_if.master iod,
  output logic [RX_WIDTH-1:0]    RX_DATA_OUT,
  output logic                   RX_DATA_VALID,
  output logic                   TRAIN_DONE,
  output logic                   TRAIN_FAIL,
  output logic [2:0]             SLIP_COUNT,
  output logic [7:0]             TAP_COUNT
);

  localparam int WW = wait_width(SETTLE_CYCLES);

  aligner_state_t state;
  logic [WW-1:0]  wait_cnt;
  logic           slip_q;
  logic           move_q;
  logic           dir_q;
  logic           load_q;
  logic           match_ok;
  logic           mismatch;
  logic           start_ok;
  logic           in_check;

  assign in_check = (state == ST_CHECK);
  assign start_ok = TRAIN_START &&
                    (state == ST_IDLE ||
                     state == ST_LOCKED ||
                     state == ST_FAIL);

  assign iod.RX_BIT_SLIP_0          = slip_q;
  assign iod.DELAY_LINE_MOVE_0      = move_q;
  assign iod.DELAY_LINE_DIRECTION_0 = dir_q;
  assign iod.DELAY_LINE_LOAD_0      = load_q;

  ddr4_rx_pattern_checker #(
    .RX_WIDTH    (RX_WIDTH),
    .PATTERN     (TRAIN_PATTERN),
    .MATCH_COUNT (MATCH_COUNT)
  ) u_checker (
    .clk      (FAB_CLK),
    .rst_n    (ARST_N),
    .en       (in_check),
    .clr      (!in_check),
    .rx_data  (iod.RX_DATA_0),
    .match_ok (match_ok),
    .mismatch (mismatch)
  );

  // Pulses default low so each is a single cycle; decisions are
  // registered, so a pulse lands in the first cycle of the next state.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      slip_q        <= 1'b0;
      move_q        <= 1'b0;
      dir_q         <= 1'b0;
      load_q        <= 1'b0;
      RX_DATA_OUT   <= '0;
      RX_DATA_VALID <= 1'b0;
      TRAIN_DONE    <= 1'b0;
      TRAIN_FAIL    <= 1'b0;
      SLIP_COUNT    <= '0;
      TAP_COUNT     <= '0;
    end else begin
      slip_q <= 1'b0;
      move_q <= 1'b0;
      dir_q  <= 1'b0;
      load_q <= 1'b0;
      if (state == ST_LOCKED) begin
        RX_DATA_OUT <= iod.RX_DATA_0;
      end
      if (start_ok) begin
        state         <= ST_LOAD;
        load_q        <= 1'b1;
        TRAIN_DONE    <= 1'b0;
        TRAIN_FAIL    <= 1'b0;
        RX_DATA_VALID <= 1'b0;
        SLIP_COUNT    <= '0;
        TAP_COUNT     <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
          end
          ST_LOAD: begin
            wait_cnt <= WW'(SETTLE_CYCLES);
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            // End stop only matters once we have stepped off the default.
            if (iod.DELAY_LINE_OUT_OF_RANGE_0 && TAP_COUNT != 8'd0) begin
              state      <= ST_FAIL;
              TRAIN_FAIL <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - WW'(1);
              if (wait_cnt <= WW'(1)) begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (match_ok) begin
              state         <= ST_LOCKED;
              TRAIN_DONE    <= 1'b1;
              RX_DATA_VALID <= 1'b1;
              RX_DATA_OUT   <= iod.RX_DATA_0;
            end else if (mismatch) begin
              wait_cnt <= WW'(SETTLE_CYCLES);
              if (SLIP_COUNT < 3'(RX_WIDTH - 1)) begin
                SLIP_COUNT <= SLIP_COUNT + 3'd1;
                slip_q     <= 1'b1;
                state      <= ST_WAIT;
              end else begin
                SLIP_COUNT <= '0;
                if (TAP_COUNT == 8'(MAX_TAPS) ||
                    iod.DELAY_LINE_OUT_OF_RANGE_0) begin
                  state      <= ST_FAIL;
                  TRAIN_FAIL <= 1'b1;
                end else begin
                  TAP_COUNT <= TAP_COUNT + 8'd1;
                  move_q    <= 1'b1;
                  dir_q     <= 1'b1;
                  state     <= ST_WAIT;
                end
              end
            end
          end
          ST_LOCKED: begin
          end
          ST_FAIL: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr4_rx_lane_aligner.sv
// Scoreboard bench for ddr4_rx_lane_aligner with a behavioural IOD model.
// Stimulus queues expected outcomes; a negedge monitor pops and compares.
module tb_ddr4_rx_lane_aligner;

  localparam int SETTLE = 8;
  localparam logic [7:0] PAT = 8'h1E;

  typedef struct {
    bit    snap;
    string name;
    int    deadline;
    int    done;
    int    fail;
    int    valid;
    int    slips;
    int    taps;
    int    pl;
    bit    chk_data;
    int    data;
    bit    chk_cnt;
    int    n_slip;
    int    n_move;
    int    n_load;
    int    b_slip;
    int    b_move;
    int    b_load;
    int    lat;
  } exp_t;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       TRAIN_START = 1'b0;
  logic [7:0] RX_DATA_OUT;
  logic       RX_DATA_VALID;
  logic       TRAIN_DONE;
  logic       TRAIN_FAIL;
  logic [2:0] SLIP_COUNT;
  logic [7:0] TAP_COUNT;

  ddr4_rx_lane_aligner_if #(.RX_WIDTH(8)) iod ();

  ddr4_rx_lane_aligner #(
    .RX_WIDTH      (8),
    .TRAIN_PATTERN (PAT),
    .MATCH_COUNT   (4),
    .SETTLE_CYCLES (SETTLE),
    .MAX_TAPS      (3)
  ) dut (
    .FAB_CLK       (FAB_CLK),
    .ARST_N        (ARST_N),
    .TRAIN_START   (TRAIN_START),
    .iod           (iod),
    .RX_DATA_OUT   (RX_DATA_OUT),
    .RX_DATA_VALID (RX_DATA_VALID),
    .TRAIN_DONE    (TRAIN_DONE),
    .TRAIN_FAIL    (TRAIN_FAIL),
    .SLIP_COUNT    (SLIP_COUNT),
    .TAP_COUNT     (TAP_COUNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  // IOD model: mode 0 rotated pattern, 1 pattern after 2 taps,
  // 2 never matches, 3 free-running byte.
  int         mode = 0;
  logic [2:0] init_off = '0;
  logic       oor = 1'b0;
  logic [2:0] off = '0;
  int         taps = 0;
  logic [7:0] cnt8 = '0;
  logic [7:0] model_data;

  function automatic logic [7:0] rotl(input logic [7:0] v,
                                      input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  always_comb begin
    model_data = 8'h00;
    case (mode)
      0: model_data = rotl(PAT, off);
      1: model_data = (taps >= 2) ? PAT : 8'h00;
      2: model_data = 8'h00;
      default: model_data = cnt8;
    endcase
  end

  assign iod.RX_DATA_0 = model_data;
  assign iod.DELAY_LINE_OUT_OF_RANGE_0 = oor;

  always @(posedge FAB_CLK) begin
    cnt8 <= cnt8 + 8'd1;
    if (iod.DELAY_LINE_LOAD_0) begin
      off  <= init_off;
      taps <= 0;
    end else begin
      if (iod.RX_BIT_SLIP_0) off <= off - 3'd1;
      if (iod.DELAY_LINE_MOVE_0) taps <= taps + 1;
    end
  end

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tot_slip = 0;
  int   tot_move = 0;
  int   tot_load = 0;
  int   last_pulse = 0;
  bit   last_v = 0;
  int   last_load = 0;
  logic done_d = 1'b0;
  logic fail_d = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.name, ".done"}, TRAIN_DONE, e.done);
    chk({e.name, ".fail"}, TRAIN_FAIL, e.fail);
    chk({e.name, ".valid"}, RX_DATA_VALID, e.valid);
    chk({e.name, ".slip_count"}, SLIP_COUNT, e.slips);
    chk({e.name, ".tap_count"}, TAP_COUNT, e.taps);
    if (e.snap)
      chk({e.name, ".pulses"},
          {iod.DELAY_LINE_LOAD_0, iod.DELAY_LINE_MOVE_0,
           iod.RX_BIT_SLIP_0}, e.pl);
    if (e.chk_data)
      chk({e.name, ".data_out"}, RX_DATA_OUT, e.data);
    if (e.chk_cnt) begin
      chk({e.name, ".n_slip"}, tot_slip - e.b_slip, e.n_slip);
      chk({e.name, ".n_move"}, tot_move - e.b_move, e.n_move);
      chk({e.name, ".n_load"}, tot_load - e.b_load, e.n_load);
    end
    if (e.lat > 0)
      chk({e.name, ".latency"}, cyc - last_load, e.lat);
  endtask

  always @(negedge FAB_CLK) begin
    logic sl;
    logic mv;
    logic ld;
    bit   ev;
    exp_t e;
    cyc++;
    sl = iod.RX_BIT_SLIP_0;
    mv = iod.DELAY_LINE_MOVE_0;
    ld = iod.DELAY_LINE_LOAD_0;
    if (!ARST_N) begin
      last_v = 0;
    end else begin
      chk("pulse_excl", (int'(sl) + int'(mv) + int'(ld) <= 1) ? 1 : 0, 1);
      chk("dir_vs_move", iod.DELAY_LINE_DIRECTION_0, mv);
      if (sl || mv || ld) begin
        if (last_v)
          chk("pulse_gap",
              (cyc - last_pulse >= ((sl || mv) ? SETTLE + 1 : 2)) ? 1 : 0, 1);
        last_pulse = cyc;
        last_v = 1;
      end
      if (RX_DATA_VALID) begin
        chk("data_pass", RX_DATA_OUT, prev_data);
        chk("valid_done", TRAIN_DONE, 1);
      end
    end
    tot_slip += int'(sl);
    tot_move += int'(mv);
    tot_load += int'(ld);
    if (ld) last_load = cyc;
    ev = ARST_N && ((TRAIN_DONE && !done_d) || (TRAIN_FAIL && !fail_d));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (e.snap || ev) begin
        compare(e);
        void'(exp_q.pop_front());
      end else if (cyc > e.deadline) begin
        chk({e.name, ".timeout"}, 0, 1);
        void'(exp_q.pop_front());
      end
    end else if (ev) begin
      chk("unexpected_completion", 0, 1);
    end
    done_d = TRAIN_DONE;
    fail_d = TRAIN_FAIL;
    prev_data = iod.RX_DATA_0;
  end

  function automatic exp_t mk(input string nm, input bit snap,
                              input int budget);
    exp_t e;
    e.snap = snap;
    e.name = nm;
    e.deadline = cyc + budget;
    e.done = 0;
    e.fail = 0;
    e.valid = 0;
    e.slips = 0;
    e.taps = 0;
    e.pl = 0;
    e.chk_data = 0;
    e.data = 0;
    e.chk_cnt = 0;
    e.n_slip = 0;
    e.n_move = 0;
    e.n_load = 0;
    e.b_slip = tot_slip;
    e.b_move = tot_move;
    e.b_load = tot_load;
    e.lat = 0;
    return e;
  endfunction

  function automatic exp_t lock_exp(input string nm, input int slips,
                                    input int taps_e, input int ns,
                                    input int nm_, input int lat);
    exp_t e;
    e = mk(nm, 0, lat + 100);
    e.done = 1;
    e.valid = 1;
    e.slips = slips;
    e.taps = taps_e;
    e.chk_cnt = 1;
    e.n_slip = ns;
    e.n_move = nm_;
    e.n_load = 1;
    e.lat = lat;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge FAB_CLK);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      tick(1);
      g++;
    end
  endtask

  task automatic pulse_start();
    TRAIN_START = 1'b1;
    tick(1);
    TRAIN_START = 1'b0;
  endtask

  initial begin
    exp_t e;
    exp_t idle;
    int   g;

    // Reset state
    tick(1);
    e = mk("reset", 1, 0);
    e.chk_data = 1;
    exp_q.push_back(e);
    tick(3);
    drain();
    ARST_N = 1'b1;
    tick(3);

    // Aligned stream: lock after LOAD + 8 wait + 4 samples + decision
    mode = 0;
    init_off = 3'd0;
    exp_q.push_back(lock_exp("aligned", 0, 0, 0, 0, 14));
    pulse_start();
    drain();
    mode = 3;
    tick(20);
    e = mk("locked_hold", 1, 0);
    e.done = 1;
    e.valid = 1;
    exp_q.push_back(e);
    drain();

    // Offset 3: three slips, no move
    mode = 0;
    init_off = 3'd3;
    exp_q.push_back(lock_exp("slip3", 3, 0, 3, 0, 44));
    pulse_start();
    drain();
    tick(5);

    // Pattern only after two delay steps
    mode = 1;
    exp_q.push_back(lock_exp("two_taps", 0, 2, 14, 2, 174));
    pulse_start();
    drain();
    tick(5);

    // Never matches, MAX_TAPS=3: 4 sweeps then FAIL
    mode = 2;
    e = mk("exhaust", 0, 500);
    e.fail = 1;
    e.taps = 3;
    e.chk_cnt = 1;
    e.n_slip = 28;
    e.n_move = 3;
    e.n_load = 1;
    e.lat = 321;
    exp_q.push_back(e);
    pulse_start();
    drain();
    e = mk("fail_hold", 1, 0);
    e.fail = 1;
    e.taps = 3;
    e.chk_cnt = 1;
    tick(30);
    exp_q.push_back(e);
    drain();

    // Restart from FAIL, then end stop after first MOVE
    mode = 2;
    oor = 1'b0;
    e = mk("oor", 0, 300);
    e.fail = 1;
    e.taps = 1;
    e.chk_cnt = 1;
    e.n_slip = 7;
    e.n_move = 1;
    e.n_load = 1;
    e.lat = 82;
    TRAIN_START = 1'b1;
    tick(1);
    TRAIN_START = 1'b0;
    idle = mk("restart", 1, 0);
    idle.pl = 3'b100;
    exp_q.push_back(idle);
    exp_q.push_back(e);
    g = 0;
    while (!iod.DELAY_LINE_MOVE_0 && g < 300) begin
      tick(1);
      g++;
    end
    oor = 1'b1;
    drain();
    oor = 1'b0;
    tick(5);

    // Reset while waiting after a slip
    mode = 0;
    init_off = 3'd3;
    pulse_start();
    g = 0;
    while (!iod.RX_BIT_SLIP_0 && g < 300) begin
      tick(1);
      g++;
    end
    tick(3);
    ARST_N = 1'b0;
    e = mk("mid_reset", 1, 0);
    e.chk_data = 1;
    exp_q.push_back(e);
    tick(3);
    drain();
    ARST_N = 1'b1;
    idle = mk("post_reset_idle", 1, 0);
    idle.chk_cnt = 1;
    tick(20);
    exp_q.push_back(idle);
    drain();

    // TRAIN_START during CHECK is ignored
    init_off = 3'd0;
    exp_q.push_back(lock_exp("start_in_check", 0, 0, 0, 0, 14));
    pulse_start();
    tick(10);
    pulse_start();
    drain();
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
